// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types for the data-memory arbiter.
package dmem_arbiter_pkg;
    typedef logic [9:0]  logic10;
    typedef logic [31:0] logic32;
    typedef enum logic {NORMAL, BOOST} arb_state_t;
    typedef enum logic [1:0] {OWNER_NONE, OWNER_CPU, OWNER_DBG} arb_owner_t;
endpackage

// File: rtl/dmem_arbiter_streak.sv
// arb_streak_counter: saturating count of contested CPU wins with clear and threshold flag.
module arb_streak_counter #(
    parameter int MAX_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic thresh_o
);
    localparam int W = $clog2(MAX_STREAK + 1);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        count_d = clr_i ? '0 : (inc_i && count_q != W'(MAX_STREAK)) ? count_q + 1'b1 : count_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end
    assign thresh_o = count_q == W'(MAX_STREAK - 1);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between the CPU (default priority) and a debug port,
// with a streak counter that forces debug through after MAX_STREAK contested CPU wins.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wd_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rd_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wd_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rd_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i
);
    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [DATA_W-1:0] cpu_rd_q, dbg_rd_q;
    logic              contested, cpu_win, dbg_win, streak_clr, streak_inc, at_thresh;

    // Grants are gated by reset so nothing reaches memory while it is held.
    assign contested = cpu_req_i & dbg_req_i;
    assign dbg_win   = rst_ni & dbg_req_i & (~cpu_req_i | state_q == BOOST);
    assign cpu_win   = rst_ni & cpu_req_i & ~dbg_win;

    assign cpu_stall_o = cpu_req_i & ~cpu_win;
    assign dbg_gnt_o   = dbg_win;
    assign mem_en_o    = cpu_win | dbg_win;
    assign mem_we_o    = cpu_win ? cpu_we_i   : dbg_win ? dbg_we_i   : 1'b0;
    assign mem_addr_o  = cpu_win ? cpu_addr_i : dbg_win ? dbg_addr_i : '0;
    assign mem_wd_o    = cpu_win ? cpu_wd_i   : dbg_win ? dbg_wd_i   : '0;

    assign streak_inc = state_q == NORMAL & contested;
    assign streak_clr = dbg_win & (state_q == BOOST | ~cpu_req_i);

    arb_streak_counter #(.MAX_STREAK(MAX_STREAK)) u_streak (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (streak_clr),
        .inc_i    (streak_inc),
        .thresh_o (at_thresh)
    );

    always_comb begin
        state_d = (streak_inc & at_thresh) ? BOOST : (state_q == BOOST & dbg_win) ? NORMAL : state_q;
        owner_d = (cpu_win & ~cpu_we_i) ? OWNER_CPU : (dbg_win & ~dbg_we_i) ? OWNER_DBG : OWNER_NONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= NORMAL;
            owner_q  <= OWNER_NONE;
            cpu_rd_q <= '0;
            dbg_rd_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (owner_q == OWNER_CPU) cpu_rd_q <= mem_rd_i;
            if (owner_q == OWNER_DBG) dbg_rd_q <= mem_rd_i;
        end
    end

    // Read data is live during the return cycle, then held until the next read to that port.
    assign cpu_rvalid_o = owner_q == OWNER_CPU;
    assign dbg_rvalid_o = owner_q == OWNER_DBG;
    assign cpu_rd_o     = cpu_rvalid_o ? mem_rd_i : cpu_rd_q;
    assign dbg_rd_o     = dbg_rvalid_o ? mem_rd_i : dbg_rd_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant priority, starvation boost, read return and reset.
module tb_dmem_arbiter;
    logic        clk = 0, rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [9:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wd, dbg_wd, mem_wd, cpu_rd, dbg_rd, mem_rd;
    logic        cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [31:0] mem [0:1023];
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd),
        .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rd_o(cpu_rd),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wd_i(dbg_wd),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rd_o(dbg_rd),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
        .mem_rd_i(mem_rd)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wd;
            else        mem_rd <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        mem_rd = 0;
        rst_n = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
        #1;
        chk("rst_cpu_stall", cpu_stall, 1);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rd", dbg_rd, 0);
        cyc(); cyc();
        rst_n = 1; cpu_req = 0;
        cyc();
        // CPU write then read-back
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h1FC; cpu_wd = 32'h4;
        #1;
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 10'h1FC);
        chk("wr_mem_wd", mem_wd, 32'h4);
        chk("wr_cpu_stall", cpu_stall, 0);
        cyc();
        cpu_we = 0;
        #1;
        chk("wr_no_rvalid", cpu_rvalid, 0);
        chk("rd_mem_we", mem_we, 0);
        cyc();
        cpu_req = 0;
        #1;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rd", cpu_rd, 32'h4);
        chk("rd_dbg_rvalid", dbg_rvalid, 0);
        cyc();
        #1;
        chk("rd_pulse_end", cpu_rvalid, 0);
        chk("rd_cpu_rd_hold", cpu_rd, 32'h4);
        // Debug write then read-back
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h1E0; dbg_wd = 32'h3C;
        #1;
        chk("dwr_gnt", dbg_gnt, 1);
        chk("dwr_mem_addr", mem_addr, 10'h1E0);
        cyc();
        dbg_we = 0;
        #1;
        chk("drd_gnt", dbg_gnt, 1);
        cyc();
        dbg_req = 0;
        #1;
        chk("drd_dbg_rvalid", dbg_rvalid, 1);
        chk("drd_dbg_rd", dbg_rd, 32'h3C);
        chk("drd_cpu_rvalid", cpu_rvalid, 0);
        cyc();
        // Preload for alternating reads
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h1F8; cpu_wd = 32'h8;
        cyc();
        cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 10'h1F0; dbg_wd = 32'h3C;
        cyc();
        dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'h1F8;
        cyc();
        cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 10'h1F0;
        #1;
        chk("alt_cpu_rvalid", cpu_rvalid, 1);
        chk("alt_cpu_rd", cpu_rd, 32'h8);
        chk("alt_dbg_rvalid0", dbg_rvalid, 0);
        cyc();
        dbg_req = 0;
        #1;
        chk("alt_dbg_rvalid", dbg_rvalid, 1);
        chk("alt_dbg_rd", dbg_rd, 32'h3C);
        chk("alt_cpu_rvalid0", cpu_rvalid, 0);
        cyc();
        // Continuous contention: period of 4 CPU wins then 1 debug win
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wd = 32'h1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h020; dbg_wd = 32'h2;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk($sformatf("starve_gnt_%0d", i), dbg_gnt, (i % 5) == 4);
            chk($sformatf("starve_stall_%0d", i), cpu_stall, (i % 5) == 4);
            chk($sformatf("starve_addr_%0d", i), mem_addr, (i % 5) == 4 ? 10'h020 : 10'h010);
            cyc();
        end
        // Now in BOOST; debug drops out, CPU proceeds, BOOST is kept
        dbg_req = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("boost_cpu_stall_%0d", i), cpu_stall, 0);
            chk($sformatf("boost_dbg_gnt_%0d", i), dbg_gnt, 0);
            cyc();
        end
        dbg_req = 1;
        #1;
        chk("boost_dbg_wins", dbg_gnt, 1);
        chk("boost_cpu_stalled", cpu_stall, 1);
        cyc();
        #1;
        chk("post_boost_cpu_wins", dbg_gnt, 0);
        chk("post_boost_stall", cpu_stall, 0);
        cyc();
        // Reset during the return cycle of a CPU read
        dbg_req = 0; cpu_we = 0; cpu_addr = 10'h1FC;
        cyc();
        rst_n = 0;
        #1;
        chk("rstmid_cpu_rvalid", cpu_rvalid, 0);
        chk("rstmid_mem_en", mem_en, 0);
        chk("rstmid_cpu_stall", cpu_stall, 1);
        cyc();
        rst_n = 1; cpu_req = 0;
        #1;
        chk("rstrel_cpu_rvalid", cpu_rvalid, 0);
        chk("rstrel_dbg_rvalid", dbg_rvalid, 0);
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h030;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h040;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rstrel_gnt_%0d", i), dbg_gnt, i == 4);
            cyc();
        end
        cpu_req = 0; dbg_req = 0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
